// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared types and defaults for the 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_RESET_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Pipeline stage register with load, hold and bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc4,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc4,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc4;
    logic             r_valid;

    // Bubble outranks load so a flush can never let a stale word through.
    always_ff @(posedge clk) begin
        if (!rst_n || i_bubble) begin
            r_instr <= NOP_VALUE;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, variable-latency fetch sequencer and IF/ID reg.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        FetchBusy
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_advance;

    logic        w_pc_write;
    logic [31:0] w_pc_next;
    logic        w_buf_write;
    logic        w_redir_write;
    logic        w_ifid_load;
    logic        w_ifid_bubble;
    logic [31:0] w_ifid_instr;

    assign w_advance  = PCWrite & IF_IDWrite;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = word_align(BranchTarget);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (BranchTaken) begin
                    w_state_next = imem_ready ? ST_FETCH : ST_DRAIN;
                end else if (imem_ready && !w_advance) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (BranchTaken || w_advance) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output and datapath control decode
    always_comb begin
        imem_req      = 1'b0;
        FetchBusy     = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_next     = w_pc_plus4;
        w_buf_write   = 1'b0;
        w_redir_write = 1'b0;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_instr  = imem_rdata;

        if (r_state == ST_FETCH || r_state == ST_DRAIN) begin
            imem_req  = 1'b1;
            FetchBusy = !imem_ready;
        end

        if (BranchTaken) begin
            w_ifid_bubble = 1'b1;
            w_pc_next     = w_target;
            case (r_state)
                ST_FETCH: begin
                    w_pc_write    = imem_ready;
                    w_redir_write = !imem_ready;
                end
                ST_DRAIN: begin
                    w_redir_write = 1'b1;
                    w_pc_write    = imem_ready;
                end
                default:  w_pc_write = 1'b1;
            endcase
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        w_ifid_load = w_advance;
                        w_pc_write  = w_advance;
                        w_buf_write = !w_advance;
                    end else begin
                        w_ifid_bubble = w_advance;
                    end
                end
                ST_HOLD: begin
                    w_ifid_load  = w_advance;
                    w_pc_write   = w_advance;
                    w_ifid_instr = r_buf;
                end
                ST_DRAIN: begin
                    w_ifid_bubble = 1'b1;
                    w_pc_write    = imem_ready;
                    w_pc_next     = r_redir_pc;
                end
                default: ;
            endcase
        end
    end

    // PC stays put while a word is buffered, so the buffered PC+4 is r_pc+4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= PC_RESET;
            r_buf      <= NOP_INSTR;
            r_redir_pc <= PC_RESET;
        end else begin
            if (w_pc_write) begin
                r_pc <= w_pc_next;
            end
            if (w_buf_write) begin
                r_buf <= imem_rdata;
            end
            if (w_redir_write) begin
                r_redir_pc <= w_target;
            end
        end
    end

    assign imem_addr = r_pc;

    if_id_reg #(
        .WIDTH     (32),
        .NOP_VALUE (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_ifid_load),
        .i_bubble (w_ifid_bubble),
        .i_instr  (w_ifid_instr),
        .i_pc4    (w_pc_plus4),
        .o_instr  (IF_ID_Instr),
        .o_pc4    (IF_ID_PC4),
        .o_valid  (IF_ID_Valid)
    );

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

PC register, instruction-memory fetch sequencer and IF/ID pipeline register for the 5-stage MIPS pipeline. It obeys the load-use stall handshake (`PCWrite`, `IF_IDWrite`) driven by the hazard detection unit and the branch redirect from ID. It issues one instruction fetch per cycle to a variable-latency instruction memory. It buffers a returned instruction while the pipe is stalled, and it drains an in-flight fetch when a redirect arrives.

## Interface
- `PC_RESET`, 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, 32'h0000_0000: instruction word inserted on bubble/flush.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `PCWrite` input 1: from hazard unit; 0 = hold PC.
- `IF_IDWrite` input 1: from hazard unit; 0 = hold IF/ID.
- `BranchTaken` input 1: one-cycle redirect pulse from ID.
- `BranchTarget` input 32: redirect PC; bits [1:0] ignored (forced 0).
- `imem_req` output 1: fetch request; held with `imem_addr` stable until `imem_ready`.
- `imem_addr` output 32: fetch address, word aligned.
- `imem_ready` input 1: `imem_rdata` valid this cycle; completes the request.
- `imem_rdata` input 32: instruction word.
- `IF_ID_Instr` output 32: registered instruction to ID.
- `IF_ID_PC4` output 32: registered PC+4 of that instruction.
- `IF_ID_Valid` output 1: 1 = real instruction, 0 = bubble.
- `FetchBusy` output 1: high in FETCH/DRAIN while `imem_ready`=0 (debug/perf).

## Operation
- `advance` = `PCWrite` & `IF_IDWrite`. Any other combination is a stall. PC and IF/ID change only together.
- **Reset** (`rst_n`=0 at an edge): state IDLE, PC=`PC_RESET`, buffer empty, `IF_ID_Instr`=`NOP_INSTR`, `IF_ID_PC4`=0, `IF_ID_Valid`=0, `imem_req`=0, `FetchBusy`=0. Reset mid-fetch abandons the request. Memory tolerates `imem_req` dropping.
- **IDLE**: `imem_req`=0; next state FETCH unconditionally.
- **FETCH**: `imem_req`=1, `imem_addr`=PC.
  - `imem_ready` & `advance`: IF/ID ← {rdata, PC+4, 1}; PC ← PC+4; stay.
  - `imem_ready` & !`advance`: buffer ← {rdata, PC+4}; IF/ID held; → HOLD.
  - !`imem_ready` & `advance`: IF/ID ← bubble (NOP, Valid=0); PC held.
  - !`imem_ready` & !`advance`: all held.
- **HOLD**: `imem_req`=0.
  - `advance`: IF/ID ← {buffer, 1}; PC ← PC+4; → FETCH.
  - Otherwise hold.
- **DRAIN**: `imem_req`=1, `imem_addr`=PC (the old address). IF/ID = bubble each cycle.
  - On `imem_ready`: discard rdata; PC ← redir_pc; → FETCH.
- **Redirect** (`BranchTaken`=1) takes priority over stall and over `imem_ready` in every state. IF/ID ← bubble unconditionally.
  - FETCH with `imem_ready`=1, or HOLD: discard data/buffer; PC ← target; → FETCH.
  - FETCH with `imem_ready`=0: redir_pc ← target; → DRAIN.
  - DRAIN: redir_pc overwritten with the new target. If `imem_ready`=1 the same cycle, PC ← new target; → FETCH.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 silently.

## Timing
- `imem_req`/`imem_addr` are combinational from state/PC registers only. There is no path from `imem_ready` to `imem_req`.
- Zero-wait memory (`imem_ready` same cycle as request) with no stalls gives one instruction per cycle. An instruction fetched in cycle n appears on IF/ID after edge n.
- A stall in the same cycle as `imem_ready` costs no refetch. Leaving HOLD to FETCH issues the next request in the following cycle, so there is one idle request cycle.
- Redirect latency: the target request is issued in the cycle after the `BranchTaken` edge. In DRAIN it is issued in the cycle after `imem_ready`.
- First request is issued in the second cycle after reset deasserts (IDLE takes one cycle).

## Structure
- Shared package `mips_pipe_pkg`:
  - fetch state enum (IDLE, FETCH, HOLD, DRAIN)
  - `NOP_INSTR` and `PC_RESET` defaults
  - `INSTR_W`=32
- Sub-module `if_id_reg`: the IF/ID register with load, hold and bubble controls. It is reusable for later stage registers.
- The FSM, PC and buffer stay in `fetch_stage`.

## Test plan
- **Reset, then zero-wait memory with `imem_ready`=1 and no stalls.** Expect `imem_addr` = 0, 4, 8, … on consecutive cycles. `IF_ID_PC4` = 4, 8, 12; `IF_ID_Valid`=1.
- **Stall coincident with `imem_ready`.** Hold `PCWrite`=`IF_IDWrite`=0 for 2 cycles while `imem_rdata`=32'h8C08_0004 returns at addr 0x10. Expect state HOLD and `imem_req`=0. On release, `IF_ID_Instr`=32'h8C08_0004 and `IF_ID_PC4`=0x14. The next request is to 0x14.
- **3-cycle memory latency.** Expect `imem_addr` stable for 3 cycles, `FetchBusy`=1 for 2 cycles, and bubbles (`IF_ID_Valid`=0) in the wait cycles.
- **Redirect during an outstanding 2-cycle request at 0x20.** `BranchTaken` with target 0x103. Expect DRAIN, and the returned 0x20 data is never valid in IF/ID. The next request is to 0x100.
- **Edge cases.**
  - Redirect and stall in the same cycle: expect flush to win, with `IF_ID_Valid`=0.
  - Redirect in HOLD: the buffer is discarded.
  - PC=32'hFFFF_FFFC advance: next `imem_addr`=0.
- **Reset asserted mid-DRAIN.** Expect all outputs at their reset values after one edge, with `imem_req`=0. The first request after release is to `PC_RESET`.
